regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port between two requesters: the core writeback path (port C) and a debug/host loader (port D).
- Core has priority; a consecutive-grant limit guarantees debug forward progress.
- Writes are registered, so the register file sees a clean one-cycle write strobe.
- Write traffic stops permanently once the program signals completion via finish_flag.

---
 rtl/regfile_write_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester arbiter for the single register-file
// write port. The core (C) has priority. A consecutive-grant streak limit
// guarantees that the debug loader (D) makes forward progress. Writes are
// registered, so the register file sees a clean one-cycle strobe. All grants
// stop permanently once finish_flag is raised.
// Optional: define REGARB_TRACE_EN for simulation-only write/halt logging.
module regfile_write_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int WAIT_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              finish_flag,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [4:0]        c_rd,
    input  logic [31:0]       c_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [4:0]        d_rd,
    input  logic [31:0]       d_data,
    output logic              wr_en,
    output logic [4:0]        wr_addr,
    output logic [31:0]       wr_data,
    output logic              halted,
    output logic [WAIT_W-1:0] d_wait_cnt
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_CONSEC);

    state_t      state, state_next;
    logic [3:0]  streak;
    logic        active, force_d;
    logic        c_xfer, d_xfer;

    assign c_xfer = c_valid && c_ready;
    assign d_xfer = d_valid && d_ready;
    assign halted = (state == HALT);

    // Next state and grants; finish_flag blocks grants in the cycle it rises.
    always_comb begin
        state_next = state;
        active     = (state == RUN) && !finish_flag;
        force_d    = 1'b0;
        c_ready    = 1'b0;
        d_ready    = 1'b0;
        if (state == RUN && finish_flag)
            state_next = HALT;
        if (active) begin
            force_d = d_valid && (streak >= MAX_S);
            c_ready = c_valid && !force_d;
            d_ready = d_valid && !c_ready;
        end
    end

    // State register; HALT is left only through reset.
    always_ff @(posedge clock) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Core-grant streak, counted only while debug is actually waiting.
    always_ff @(posedge clock) begin
        if (reset)
            streak <= '0;
        else if (!d_valid || d_xfer)
            streak <= '0;
        else if (c_xfer && streak < MAX_S)
            streak <= streak + 4'd1;
    end

    // Registered write port; rd=0 transfers complete but never strobe x0.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (c_xfer && c_rd != 5'd0) begin
            wr_en   <= 1'b1;
            wr_addr <= c_rd;
            wr_data <= c_data;
        end else if (d_xfer && d_rd != 5'd0) begin
            wr_en   <= 1'b1;
            wr_addr <= d_rd;
            wr_data <= d_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Saturating count of cycles debug spends stalled, including in HALT.
    always_ff @(posedge clock) begin
        if (reset)
            d_wait_cnt <= '0;
        else if (d_valid && !d_ready && !(&d_wait_cnt))
            d_wait_cnt <= d_wait_cnt + WAIT_W'(1);
    end

`ifdef REGARB_TRACE_EN
    logic wr_from_d;

    // Remember which port produced the pending write, for the log only.
    always_ff @(posedge clock) begin
        if (reset)       wr_from_d <= 1'b0;
        else if (c_xfer) wr_from_d <= 1'b0;
        else if (d_xfer) wr_from_d <= 1'b1;
    end

    // Simulation log of writes, dropped x0 writes and HALT entry.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wr_en)
                $display("regarb: port %s x%0d <= %0d", wr_from_d ? "D" : "C",
                         wr_addr, $signed(wr_data));
            if ((c_xfer && c_rd == 5'd0) || (d_xfer && d_rd == 5'd0))
                $display("regarb: x0 write dropped");
            if (state == RUN && state_next == HALT)
                $display("regarb: entering HALT");
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Expected writes are queued when a
// grant is expected and checked when wr_en appears; state outputs are checked
// mid-cycle against hand-derived values.
module tb_regfile_write_arbiter;

    localparam int WAIT_W = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              finish_flag;
    logic              c_valid, d_valid;
    logic              c_ready, d_ready;
    logic [4:0]        c_rd, d_rd;
    logic [31:0]       c_data, d_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              halted;
    logic [WAIT_W-1:0] d_wait_cnt;

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q[$];
    logic [WAIT_W-1:0] w0;

    regfile_write_arbiter #(.MAX_CONSEC(4), .WAIT_W(WAIT_W)) dut (
        .clock(clock), .reset(reset), .finish_flag(finish_flag),
        .c_valid(c_valid), .c_ready(c_ready), .c_rd(c_rd), .c_data(c_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_rd(d_rd), .d_data(d_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .halted(halted), .d_wait_cnt(d_wait_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every wr_en pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr_en", {63'b0, wr_en}, 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("sb_wr_addr", {59'b0, wr_addr}, {59'b0, e[36:32]});
                chk("sb_wr_data", {32'b0, wr_data}, {32'b0, e[31:0]});
            end
        end
    end

    initial begin
        reset = 1'b1; finish_flag = 1'b0;
        c_valid = 1'b0; c_rd = '0; c_data = '0;
        d_valid = 1'b0; d_rd = '0; d_data = '0;
        #1;
        next_cycle();
        @(negedge clock);
        chk("rst_wr_en", {63'b0, wr_en}, 64'd0);
        chk("rst_wr_addr", {59'b0, wr_addr}, 64'd0);
        chk("rst_wr_data", {32'b0, wr_data}, 64'd0);
        chk("rst_halted", {63'b0, halted}, 64'd0);
        chk("rst_wait", {48'b0, d_wait_cnt}, 64'd0);
        next_cycle();
        reset = 1'b0;

        // Core only, rd=5 data=-7
        c_valid = 1'b1; c_rd = 5'd5; c_data = -32'sd7;
        @(negedge clock);
        chk("core_c_ready", {63'b0, c_ready}, 64'd1);
        chk("core_d_ready", {63'b0, d_ready}, 64'd0);
        exp_q.push_back({5'd5, 32'hFFFF_FFF9});
        next_cycle();
        c_valid = 1'b0;
        @(negedge clock);
        chk("core_wr_en", {63'b0, wr_en}, 64'd1);
        chk("core_wr_data", {32'b0, wr_data}, 64'hFFFF_FFF9);
        next_cycle();
        @(negedge clock);
        chk("core_wr_en_off", {63'b0, wr_en}, 64'd0);

        // Debug only is granted at once
        next_cycle();
        d_valid = 1'b1; d_rd = 5'd2; d_data = 32'h55;
        @(negedge clock);
        chk("dbg_d_ready", {63'b0, d_ready}, 64'd1);
        exp_q.push_back({5'd2, 32'h55});
        next_cycle();
        d_valid = 1'b0;

        // Contention: four core grants, then debug forced through
        next_cycle();
        d_valid = 1'b1; d_rd = 5'd9; d_data = 32'd100;
        c_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            c_rd = 5'(10 + i); c_data = 32'(1000 + i);
            @(negedge clock);
            if (i < 4) begin
                chk("cont_c_ready", {63'b0, c_ready}, 64'd1);
                chk("cont_d_ready", {63'b0, d_ready}, 64'd0);
                exp_q.push_back({5'(10 + i), 32'(1000 + i)});
            end else begin
                chk("force_c_ready", {63'b0, c_ready}, 64'd0);
                chk("force_d_ready", {63'b0, d_ready}, 64'd1);
                exp_q.push_back({5'd9, 32'd100});
            end
            next_cycle();
        end
        d_valid = 1'b0;
        c_rd = 5'd20; c_data = 32'd2000;
        @(negedge clock);
        chk("resume_c_ready", {63'b0, c_ready}, 64'd1);
        chk("cont_wait_cnt", {48'b0, d_wait_cnt}, 64'd4);
        exp_q.push_back({5'd20, 32'd2000});
        next_cycle();

        // x0 drop followed by a real write to x3
        c_rd = 5'd0; c_data = 32'h1234;
        @(negedge clock);
        chk("x0_c_ready", {63'b0, c_ready}, 64'd1);
        next_cycle();
        c_rd = 5'd3; c_data = 32'd77;
        @(negedge clock);
        chk("x0_no_wr_en", {63'b0, wr_en}, 64'd0);
        chk("x0_hold_addr", {59'b0, wr_addr}, 64'd20);
        exp_q.push_back({5'd3, 32'd77});
        next_cycle();
        c_valid = 1'b0;
        @(negedge clock);
        chk("x3_wr_en", {63'b0, wr_en}, 64'd1);
        chk("x3_wr_addr", {59'b0, wr_addr}, 64'd3);
        next_cycle();

        // Finish: transfer in N, finish_flag in N+1
        c_valid = 1'b1; c_rd = 5'd7; c_data = 32'hABCD;
        @(negedge clock);
        chk("fin_n_c_ready", {63'b0, c_ready}, 64'd1);
        exp_q.push_back({5'd7, 32'hABCD});
        next_cycle();
        finish_flag = 1'b1; d_valid = 1'b1; c_rd = 5'd8; d_rd = 5'd4;
        @(negedge clock);
        chk("fin_wr_en", {63'b0, wr_en}, 64'd1);
        chk("fin_c_ready", {63'b0, c_ready}, 64'd0);
        chk("fin_d_ready", {63'b0, d_ready}, 64'd0);
        chk("fin_halted_n1", {63'b0, halted}, 64'd0);
        w0 = d_wait_cnt;
        next_cycle();
        finish_flag = 1'b0;
        @(negedge clock);
        chk("halt_halted", {63'b0, halted}, 64'd1);
        chk("halt_c_ready", {63'b0, c_ready}, 64'd0);
        chk("halt_d_ready", {63'b0, d_ready}, 64'd0);
        chk("halt_wr_en", {63'b0, wr_en}, 64'd0);
        chk("halt_wait1", {48'b0, d_wait_cnt}, {48'b0, w0 + 16'd1});
        next_cycle();
        @(negedge clock);
        chk("halt_sticky", {63'b0, halted}, 64'd1);
        chk("halt_wait2", {48'b0, d_wait_cnt}, {48'b0, w0 + 16'd2});

        // Reset out of HALT
        next_cycle();
        reset = 1'b1; c_valid = 1'b0; d_valid = 1'b0;
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("unhalt", {63'b0, halted}, 64'd0);

        // Reset mid-write: transfer in N, reset in N+1 (with another request)
        next_cycle();
        c_valid = 1'b1; c_rd = 5'd4; c_data = 32'h99;
        @(negedge clock);
        chk("rmw_c_ready", {63'b0, c_ready}, 64'd1);
        exp_q.push_back({5'd4, 32'h99});
        next_cycle();
        reset = 1'b1; c_rd = 5'd6; c_data = 32'h66;
        next_cycle();
        reset = 1'b0; c_valid = 1'b0;
        @(negedge clock);
        chk("rmw_wr_en", {63'b0, wr_en}, 64'd0);
        chk("rmw_wr_addr", {59'b0, wr_addr}, 64'd0);
        chk("rmw_wr_data", {32'b0, wr_data}, 64'd0);
        chk("rmw_halted", {63'b0, halted}, 64'd0);
        chk("rmw_wait", {48'b0, d_wait_cnt}, 64'd0);
        next_cycle();
        @(negedge clock);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
